// File: rtl/fdiv_issue_queue.sv
// fdiv_issue_queue: request FIFO + launch FSM + result register in front of the NR divider (optional watchdog: FDIV_TIMEOUT_EN)
module fdiv_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int TAGW    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_a,
  input  logic [31:0]                req_b,
  input  logic [1:0]                 req_rm,
  input  logic [TAGW-1:0]            req_tag,
  output logic [31:0]                div_a,
  output logic [31:0]                div_b,
  output logic [1:0]                 div_rm,
  output logic                       div_fdiv,
  output logic                       div_ena,
  input  logic                       div_stall,
  input  logic [31:0]                div_s,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [31:0]                res_data,
  output logic [TAGW-1:0]            res_tag,
  output logic                       res_err,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;
  state_t state_q, state_d;
  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  logic [1:0] mem_rm [DEPTH];
  logic [TAGW-1:0] mem_tag [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic [TAGW-1:0] tag_q;
  logic push, pop, done, abort;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("fdiv_issue_queue: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end
  assign req_ready = cnt_q != (AW+1)'(DEPTH);
  assign push = req_valid & req_ready;
  assign pop = state_q == IDLE && cnt_q != '0 && !res_valid;
  assign done = state_q == WAIT && !div_stall;
  assign occupancy = cnt_q;
  assign div_ena = 1'b1;
  // Request storage; no reset needed, entries are only read once counted valid.
  always_ff @(posedge clk)
    if (push) begin
      mem_a[wp_q] <= req_a;
      mem_b[wp_q] <= req_b;
      mem_rm[wp_q] <= req_rm;
      mem_tag[wp_q] <= req_tag;
    end
  // FIFO pointers and fill count; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk)
    if (clr) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_q + AW'(push);
      rp_q <= rp_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  // Operand latch: loaded only at launch so it stays stable while div_fdiv is high.
  always_ff @(posedge clk)
    if (clr) begin
      div_a <= '0;
      div_b <= '0;
      div_rm <= '0;
      tag_q <= '0;
    end else if (pop) begin
      div_a <= mem_a[rp_q];
      div_b <= mem_b[rp_q];
      div_rm <= mem_rm[rp_q];
      tag_q <= mem_tag[rp_q];
    end
  // Launch FSM state register.
  always_ff @(posedge clk)
    if (clr) state_q <= IDLE;
    else state_q <= state_d;
  // Next state and divider request; GAP forces a low cycle so every launch is a fresh rising edge.
  always_comb begin
    state_d = state_q == IDLE ? (pop ? LAUNCH : IDLE) :
              state_q == LAUNCH ? WAIT :
              state_q == WAIT ? (done || abort ? GAP : WAIT) : IDLE;
    div_fdiv = state_q == LAUNCH || state_q == WAIT;
  end
  // One-entry result register; a launch never starts while it is full, so it is never overwritten.
  always_ff @(posedge clk)
    if (clr) begin
      res_valid <= 1'b0;
      res_data <= '0;
      res_tag <= '0;
    end else if (done || abort) begin
      res_valid <= 1'b1;
      res_data <= abort ? 32'h7fc00000 : div_s;
      res_tag <= tag_q;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
`ifdef FDIV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q;
  logic err_q;
  assign abort = state_q == WAIT && div_stall && tmo_q == TW'(TIMEOUT - 1);
  assign res_err = err_q;
  // Watchdog counts WAIT cycles and restarts whenever the FSM leaves WAIT.
  always_ff @(posedge clk)
    if (clr || state_q != WAIT) tmo_q <= '0;
    else tmo_q <= tmo_q + TW'(1);
  // Error flag travels with the result and clears when it is consumed.
  always_ff @(posedge clk)
    if (clr) err_q <= 1'b0;
    else if (done || abort) err_q <= abort;
    else if (res_valid && res_ready) err_q <= 1'b0;
`else
  assign abort = 1'b0;
  assign res_err = 1'b0;
`endif
endmodule

// File: tb/tb_fdiv_issue_queue.sv
// tb_fdiv_issue_queue: random and directed traffic against a timeline model of queue, divider and result slot
module tb_fdiv_issue_queue;
  localparam int DEPTH = 4;
  localparam int TAGW = 4;
  localparam int TMO = 64;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0] rm;
    logic [TAGW-1:0] tag;
  } req_t;
  logic clk, clr, req_valid, req_ready, div_fdiv, div_ena, div_stall;
  logic res_valid, res_ready, res_err;
  logic [31:0] req_a, req_b, div_a, div_b, div_s, res_data;
  logic [1:0] req_rm, div_rm;
  logic [TAGW-1:0] req_tag, res_tag;
  logic [$clog2(DEPTH):0] occupancy;
  int vec, bad, k, lat, dcnt, done_edge, next_ok;
  bit busy, mfull, merr, abrt;
  logic [31:0] mdata;
  logic [TAGW-1:0] mtag;
  req_t q[$];
  req_t cur;
  logic [TAGW-1:0] seen[$];

  fdiv_issue_queue #(.DEPTH(DEPTH), .TAGW(TAGW), .TIMEOUT(TMO)) dut (
    .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm), .req_tag(req_tag),
    .div_a(div_a), .div_b(div_b), .div_rm(div_rm), .div_fdiv(div_fdiv),
    .div_ena(div_ena), .div_stall(div_stall), .div_s(div_s),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_err(res_err), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
    if (a == 32'h440e11ec && b == 32'h4311c7ae) return 32'h40797a2b;
    return a ^ {b[15:0], b[31:16]} ^ {30'd0, rm};
  endfunction

  // Bench divider: stall in the launch cycle and the next lat cycles, then one completion cycle.
  always @(posedge clk) dcnt <= (clr || !div_fdiv) ? 0 : dcnt + 1;
  assign div_stall = div_fdiv && dcnt <= lat;
  assign div_s = quot(div_a, div_b, div_rm);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, k);
    end
  endtask

  function automatic bit pop_next();
    return !clr && !busy && k + 1 >= next_ok && q.size() > 0 && !mfull;
  endfunction

  task automatic step();
    int sz;
    bit psh, rel, pp, comp;
    if (res_valid && res_ready) seen.push_back(res_tag);
    sz = q.size();
    psh = req_valid && sz < DEPTH;
    rel = mfull && res_ready;
    pp = pop_next();
    comp = busy && k + 1 == done_edge;
    @(posedge clk);
    k++;
    if (clr) begin
      q.delete();
      busy = 0; mfull = 0; merr = 0; mdata = '0; mtag = '0; next_ok = 0;
      cur = '0;
    end else begin
      if (rel) begin mfull = 0; merr = 0; end
      if (comp) begin
        mfull = 1;
        mtag = cur.tag;
        mdata = abrt ? 32'h7fc00000 : quot(cur.a, cur.b, cur.rm);
        merr = abrt;
        busy = 0;
        next_ok = k + 2;
      end
      if (pp) begin
        cur = q.pop_front();
        busy = 1;
        abrt = 0;
        done_edge = k + lat + 2;
`ifdef FDIV_TIMEOUT_EN
        if (lat >= TMO) begin abrt = 1; done_edge = k + TMO + 1; end
`endif
      end
      if (psh) q.push_back('{req_a, req_b, req_rm, req_tag});
    end
    #1;
    check("occupancy", occupancy, q.size());
    check("req_ready", req_ready, q.size() < DEPTH);
    check("div_fdiv", div_fdiv, busy);
    check("res_valid", res_valid, mfull);
    check("res_err", res_err, merr);
    check("res_data", res_data, mdata);
    check("res_tag", res_tag, mtag);
    check("div_a", div_a, cur.a);
    check("div_b", div_b, cur.b);
    check("div_rm", div_rm, cur.rm);
    check("div_ena", div_ena, 1);
  endtask

  task automatic rand_req(input logic [TAGW-1:0] t);
    req_a = $urandom; req_b = $urandom; req_rm = 2'($urandom_range(0, 3)); req_tag = t;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() > 0 || busy || mfull) && n < 400) begin step(); n++; end
    check("drain_bound", n < 400, 1);
  endtask

  task automatic wait_result();
    int n = 0;
    while (!mfull && n < 200) begin step(); n++; end
    check("result_bound", n < 200, 1);
  endtask

  initial begin
    int hi, tg, n;
    bit was_full;
    vec = 0; bad = 0; k = 0; lat = 3; next_ok = 0; done_edge = -1;
    busy = 0; mfull = 0; merr = 0; abrt = 0; mdata = '0; mtag = '0; cur = '0;
    clr = 1; req_valid = 0; res_ready = 0; rand_req('0);
    step(); step();
    clr = 0;
    check("rst_occupancy", occupancy, 0);
    check("rst_ready", req_ready, 1);
    check("rst_res_data", res_data, 0);
    // Reset while the divider is stuck mid-iteration
    lat = 100; req_valid = 1; rand_req(4'd9);
    step();
    req_valid = 0;
    repeat (6) step();
    check("t1_inflight", div_fdiv, 1);
    clr = 1; step(); clr = 0;
    check("t1_fdiv", div_fdiv, 0);
    check("t1_occ", occupancy, 0);
    check("t1_valid", res_valid, 0);
    check("t1_ready", req_ready, 1);
    check("t1_div_a", div_a, 0);
    // Single known request
    lat = 5; res_ready = 0; req_valid = 1;
    req_a = 32'h440e11ec; req_b = 32'h4311c7ae; req_rm = 2'd0; req_tag = 4'd3;
    step();
    req_valid = 0; hi = 0;
    repeat (12) begin step(); if (div_fdiv) hi++; end
    check("t2_fdiv_cycles", hi, 7);
    check("t2_data", res_data, 32'h40797a2b);
    check("t2_tag", res_tag, 3);
    check("t2_valid", res_valid, 1);
    res_ready = 1; step();
    check("t2_cleared", res_valid, 0);
    // DEPTH+1 back-to-back requests, results in order
    drain();
    lat = $urandom_range(1, 4); seen.delete(); tg = 0; n = 0; was_full = 0;
    while (tg < DEPTH + 1 && n < 200) begin
      req_valid = 1; rand_req(4'(tg));
      if (q.size() < DEPTH) tg++;
      step(); n++;
      if (!req_ready) was_full = 1;
    end
    req_valid = 0;
    check("t3_push_bound", n < 200, 1);
    check("t3_full_seen", was_full, 1);
    drain();
    check("t3_count", seen.size(), DEPTH + 1);
    for (int i = 0; i < seen.size(); i++) check("t3_order", seen[i], i);
    // Back-pressure from the consumer blocks further launches
    res_ready = 0;
    for (int i = 0; i < 2; i++) begin req_valid = 1; rand_req(4'(i + 6)); step(); end
    req_valid = 0;
    wait_result();
    repeat (20) begin step(); check("t4_nolaunch", div_fdiv, 0); end
    res_ready = 1; step(); step();
    check("t4_relaunch", div_fdiv, 1);
    drain();
    // Push and pop on the same edge at occupancy 2
    lat = 3; req_valid = 1;
    for (int i = 0; i < 3; i++) begin rand_req(4'(i)); step(); end
    req_valid = 0; n = 0;
    while (!pop_next() && n < 50) begin step(); n++; end
    check("t5_bound", n < 50, 1);
    check("t5_occ_before", occupancy, 2);
    req_valid = 1; rand_req(4'd12); step(); req_valid = 0;
    check("t5_occ", occupancy, 2);
    drain();
    // Random traffic
    repeat (600) begin
      if (!busy && $urandom_range(0, 3) == 0) lat = $urandom_range(0, 4);
      req_valid = $urandom_range(0, 1); rand_req(4'($urandom));
      res_ready = $urandom_range(0, 2) != 0;
      step();
    end
    req_valid = 0; res_ready = 1;
    drain();
`ifdef FDIV_TIMEOUT_EN
    // Watchdog abort, then a normal completion
    lat = 1000; res_ready = 0; req_valid = 1;
    req_a = 32'h41074bc7; req_b = 32'hc1ae3d71; req_rm = 2'd1; req_tag = 4'd5;
    step(); req_valid = 0;
    wait_result();
    check("t6_nan", res_data, 32'h7fc00000);
    check("t6_err", res_err, 1);
    res_ready = 1; step();
    check("t6_err_clr", res_err, 0);
    drain();
    lat = 2; res_ready = 0; req_valid = 1; rand_req(4'd6);
    step(); req_valid = 0;
    wait_result();
    check("t6_ok_err", res_err, 0);
    res_ready = 1;
    drain();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
